// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM encoding and counter width.
package alu_pkg;

    localparam int unsigned CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_scheduler_if.sv
// Bundle of the requester, shared-ALU and response signals around alu_scheduler.
interface alu_scheduler_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [2:0]            req0_control;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [2:0]            req1_control;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic [2:0]            alu_control;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_ready;

    // Requesters, response consumer and the shared ALU live on the master side.
    modport master (
        output req0_valid, req0_control, req0_a, req0_b,
        output req1_valid, req1_control, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready, alu_control, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req0_valid, req0_control, req0_a, req0_b,
        input  req1_valid, req1_control, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready, alu_control, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-way arbiter with one-hot grant; round-robin by default, fixed priority
// (req0 wins ties) when ALU_SCHED_FIXED_PRIO_EN is defined.
module alu_rr_arbiter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // ptr_q == 0 favours req0, 1 favours req1
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = '0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end
`else
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
`endif
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters, one operation in flight.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed-priority instead of round-robin arbitration.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [2:0]            req0_control,
    input  logic [2:0]            req1_control,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [2:0]            alu_control,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    input  logic                  rsp_ready
);

    localparam cnt_t MUL_CNT = cnt_t'(MUL_LAT);

    state_e                state_q, state_d;
    cnt_t                  cnt_q, cnt_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic                  idle;
    logic [1:0]            gnt;
    logic [2:0]            sel_ctrl;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;

    assign idle = (state_q == S_IDLE);

    // Requests are masked outside IDLE so ready and the pointer only move on a real accept.
    alu_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (reset),
        .req_i ({req1_valid, req0_valid} & {2{idle}}),
        .en_i  (idle),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign sel_ctrl   = gnt[1] ? req1_control : req0_control;
    assign sel_a      = gnt[1] ? req1_a : req0_a;
    assign sel_b      = gnt[1] ? req1_b : req0_b;

    assign alu_control = ctrl_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    ctrl_d  = sel_ctrl;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = gnt[1];
                    cnt_d   = (sel_ctrl == OP_MUL) ? MUL_CNT : cnt_t'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == cnt_t'(1)) begin
                    rsp_result_d = alu_result;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ctrl_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler (MUL_LAT=3) with a behavioural shared ALU.
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    typedef struct {
        logic          id;
        logic [DW-1:0] res;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    alu_scheduler #(.DATA_WIDTH(DW), .MUL_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (bus.req0_valid),
        .req1_valid   (bus.req1_valid),
        .req0_ready   (bus.req0_ready),
        .req1_ready   (bus.req1_ready),
        .req0_control (bus.req0_control),
        .req1_control (bus.req1_control),
        .req0_a       (bus.req0_a),
        .req0_b       (bus.req0_b),
        .req1_a       (bus.req1_a),
        .req1_b       (bus.req1_b),
        .alu_control  (bus.alu_control),
        .alu_a        (bus.alu_a),
        .alu_b        (bus.alu_b),
        .alu_result   (bus.alu_result),
        .rsp_valid    (bus.rsp_valid),
        .rsp_id       (bus.rsp_id),
        .rsp_result   (bus.rsp_result),
        .rsp_ready    (bus.rsp_ready)
    );

    function automatic logic [DW-1:0] alu_model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_control, bus.alu_a, bus.alu_b);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops on each new response, checks stability while held.
    initial begin : monitor
        exp_t          e;
        logic          prev_v;
        logic          prev_id;
        logic [DW-1:0] prev_res;
        prev_v   = 1'b0;
        prev_id  = 1'b0;
        prev_res = '0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                check("ready_while_rsp", DW'({bus.req1_ready, bus.req0_ready}), '0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_rsp: got id %0d result %h, required no response", bus.rsp_id, bus.rsp_result);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", DW'(bus.rsp_id), DW'(e.id));
                        check("rsp_result", bus.rsp_result, e.res);
                        if (e.cyc != 0) check("rsp_latency", DW'(cyc), DW'(e.cyc));
                    end
                end else begin
                    check("hold_id", DW'(bus.rsp_id), DW'(prev_id));
                    check("hold_result", bus.rsp_result, prev_res);
                end
            end
            prev_v   = (bus.rsp_valid === 1'b1);
            prev_id  = bus.rsp_id;
            prev_res = bus.rsp_result;
        end
    end

    task automatic drive(input int port, input logic v, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_control = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_control = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int port, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] res);
        int unsigned lat;
        bit seen;
        lat  = (op == OP_MUL) ? LAT : 1;
        seen = 1'b0;
        drive(port, 1'b1, op, a, b);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((port == 0) ? bus.req0_ready : bus.req1_ready) seen = 1'b1;
        end
        check("req_ready", DW'(seen), DW'(1));
        if (seen) begin
            sb.push_back('{id: port[0], res: res, cyc: cyc + 1 + int'(lat)});
            @(posedge clk);
            #1;
        end
        drive(port, 1'b0, op, a, b);
        if (seen && op == OP_MUL) begin
            for (int k = 0; k < int'(LAT); k++) begin
                @(negedge clk);
                check("alu_ctrl_stable", DW'(bus.alu_control), DW'(op));
                check("alu_a_stable", bus.alu_a, a);
                check("alu_b_stable", bus.alu_b, b);
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.rsp_valid === 1'b0) done = 1'b1;
        end
        check("drain", DW'(done), DW'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int  exp_order[4];
        int  ng;
        bit  seen;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        drive(0, 1'b0, 3'b000, '0, '0);
        drive(1, 1'b0, 3'b000, '0, '0);
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", DW'(bus.rsp_valid), '0);
        check("rst_rsp_id", DW'(bus.rsp_id), '0);
        check("rst_rsp_result", bus.rsp_result, '0);
        check("rst_alu_ctrl", DW'(bus.alu_control), '0);
        check("rst_alu_a", bus.alu_a, '0);
        check("rst_alu_b", bus.alu_b, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.rsp_ready = 1'b1;

        issue(0, OP_ADD, 32'd5, 32'd3, 32'd8);                       drain();
        issue(1, OP_MUL, 32'd7, 32'd6, 32'd42);                      drain();
        issue(0, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);               drain();
        issue(1, 3'b111, 32'd9, 32'd9, 32'd0);                       drain();

        // Both requesters held valid: req0 computes 1+1, req1 computes 2+2.
        for (int k = 0; k < 4; k++)
            sb.push_back('{id: exp_order[k][0], res: (exp_order[k] == 0) ? 32'd2 : 32'd4, cyc: 0});
        drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        drive(1, 1'b1, OP_ADD, 32'd2, 32'd2);
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                check("grant_onehot", DW'(bus.req0_ready & bus.req1_ready), '0);
                check("grant_order", DW'(bus.req1_ready), DW'(exp_order[ng]));
                ng++;
            end
        end
        check("grant_count", DW'(ng), DW'(4));
        @(posedge clk);
        #1;
        drive(0, 1'b0, OP_ADD, '0, '0);
        drive(1, 1'b0, OP_ADD, '0, '0);
        drain();

        // Back-pressure: response held 5 cycles while req1 waits.
        bus.rsp_ready = 1'b0;
        issue(0, OP_XOR, 32'hF0, 32'hFF, 32'h0F);
        sb.push_back('{id: 1'b1, res: 32'h08, cyc: 0});
        drive(1, 1'b1, OP_AND, 32'h0C, 32'h0A);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("hold_rsp_seen", DW'(seen), DW'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", DW'(bus.rsp_valid), DW'(1));
            check("hold_req1_ready", DW'(bus.req1_ready), '0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.req1_ready) seen = 1'b1;
        end
        check("req1_after_hold", DW'(seen), DW'(1));
        @(posedge clk);
        #1 drive(1, 1'b0, OP_AND, '0, '0);
        drain();

        // Reset during a multiply: everything clears, no response follows.
        drive(0, 1'b1, OP_MUL, 32'd3, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.req0_ready) seen = 1'b1;
        end
        check("mul_accept", DW'(seen), DW'(1));
        @(posedge clk);
        #1 drive(0, 1'b0, OP_MUL, '0, '0);
        #2 reset = 1'b0;
        #1;
        check("midrst_rsp_valid", DW'(bus.rsp_valid), '0);
        check("midrst_rsp_id", DW'(bus.rsp_id), '0);
        check("midrst_rsp_result", bus.rsp_result, '0);
        check("midrst_alu_ctrl", DW'(bus.alu_control), '0);
        check("midrst_alu_a", bus.alu_a, '0);
        check("midrst_alu_b", bus.alu_b, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(negedge clk);
        check("sb_empty", DW'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 SHALL have parameter MUL_LAT, default 2: cycles operands are held for opcode 3'b010 (multiply); legal range 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each: requester has an operation pending.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each: operation accepted this cycle.
REQ-007 SHALL have ports req0_control/req1_control, input, 3 each: opcode (000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor, others give result 0).
REQ-008 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, DATA_WIDTH each: operands.
REQ-009 SHALL have ports alu_control (output, 3), alu_a (output, DATA_WIDTH), alu_b (output, DATA_WIDTH): drive the shared combinational ALU.
REQ-010 SHALL have port alu_result, input, DATA_WIDTH: shared ALU output.
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1), rsp_result (output, DATA_WIDTH), rsp_ready (input, 1): response channel.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-013 In IDLE, when at least one reqN_valid is high, SHALL assert the winner's reqN_ready combinationally, latch its control/a/b and index, and enter EXEC on that edge.
REQ-014 reqN_ready SHALL be high only in IDLE, only for the winner, and never for both requesters.
REQ-015 Arbitration SHALL be round-robin: after a grant to N, the other requester has priority; the pointer changes only on a grant.
REQ-016 alu_control/alu_a/alu_b SHALL always equal the latched registers, stable throughout EXEC.
REQ-017 EXEC SHALL last MUL_LAT cycles for opcode 010 and exactly 1 cycle for all other opcodes, including 110/111, counted by a down-counter loaded on accept.
REQ-018 On the last EXEC cycle, SHALL capture alu_result into rsp_result, set rsp_id to the latched index, assert rsp_valid and enter DONE.
REQ-019 Latency: an operation accepted at edge N SHALL raise rsp_valid after edge N+1 (non-mul) or N+MUL_LAT (mul).
REQ-020 In DONE, SHALL hold rsp_valid/rsp_id/rsp_result stable until rsp_ready is high; on that edge SHALL clear rsp_valid and return to IDLE.
REQ-021 No new request SHALL be accepted in the cycle rsp_ready completes; next accept is earliest the following cycle (one operation in flight, no bypass).
REQ-022 Arithmetic SHALL be taken unmodified from alu_result (modulo 2^DATA_WIDTH wrap, no overflow flag).

Reset
REQ-023 On reset low, SHALL immediately force state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, latched control/a/b 0, counter 0, RR pointer favoring req0.
REQ-024 Reset mid-EXEC or mid-DONE SHALL discard the in-flight operation with no response.

Configuration
REQ-025 With macro ALU_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (req0 always wins ties); without it, round-robin per REQ-015.

Structure
REQ-026 Opcode constants, the FSM state encoding and the counter width SHALL live in shared package alu_pkg.
REQ-027 Arbitration SHALL be a sub-module alu_rr_arbiter (2 requests in, one-hot grant out, pointer update enable).

Verification
REQ-028 Reset pulse during a MUL_LAT=3 EXEC -> all outputs 0 within the reset cycle, no rsp_valid afterwards.
REQ-029 req0 add A=5 B=3, rsp_ready=1 -> req0_ready one cycle, rsp_valid one cycle later, rsp_result=8, rsp_id=0.
REQ-030 MUL_LAT=3, req1 mul A=7 B=6 -> alu_a/alu_b stable 3 cycles, rsp_valid 3 cycles after accept, rsp_result=42, rsp_id=1.
REQ-031 Both requesters valid continuously -> grant order 0,1,0,1; with ALU_SCHED_FIXED_PRIO_EN -> 0,0,0,0.
REQ-032 rsp_ready low 5 cycles after rsp_valid -> response held unchanged, both reqN_ready stay 0.
REQ-033 Sub A=0 B=1 -> rsp_result=32'hFFFFFFFF; opcode 3'b111 -> rsp_result=0 with 1-cycle latency.
